alu_core: RTL and testbench



---
 rtl/alu_core.sv | 160 ++++++++++++++++
 tb/tb_alu_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
`default_nettype none
//============================================================================
// Module   : alu_core
// Purpose  : WIDTH-bit arithmetic/logic unit for the CPU datapath. The result
//            is purely combinational. A clocked status register captures the
//            zero/negative/carry/overflow flags used for conditional branches.
// Revision : 1.0 - initial release
//============================================================================
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       select,
    input  logic             flag_en,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    // Operation codes
    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_mul   = 4'b0010;
    localparam logic [3:0] c_op_div   = 4'b0011;
    localparam logic [3:0] c_op_and   = 4'b0100;
    localparam logic [3:0] c_op_or    = 4'b0101;
    localparam logic [3:0] c_op_xor   = 4'b0110;
    localparam logic [3:0] c_op_shl   = 4'b0111;
    localparam logic [3:0] c_op_shr   = 4'b1000;
    localparam logic [3:0] c_op_asr   = 4'b1001;
    localparam logic [3:0] c_op_passa = 4'b1010;
    localparam logic [3:0] c_op_passb = 4'b1011;
    localparam logic [3:0] c_op_cmp   = 4'b1100;

    // Shift amounts use only the low bits once the full amount is known
    // to be below WIDTH; anything at or above WIDTH saturates.
    localparam int               c_shw      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_sh_limit = WIDTH'(WIDTH);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic               w_div_zero;
    logic               w_sh_big;
    logic [c_shw-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_shl;
    logic [WIDTH-1:0]   w_shr;
    logic [WIDTH-1:0]   w_asr;
    logic [WIDTH-1:0]   w_result;
    logic               w_z;
    logic               w_n;
    logic               w_c;
    logic               w_v;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_sign_r;

    logic               r_flag_z;
    logic               r_flag_n;
    logic               r_flag_c;
    logic               r_flag_v;

    // Shared arithmetic datapath; the extra top bit of sum/diff is carry/borrow.
    assign w_sum      = {1'b0, in0} + {1'b0, in1};
    assign w_diff     = {1'b0, in0} - {1'b0, in1};
    assign w_prod     = {{WIDTH{1'b0}}, in0} * {{WIDTH{1'b0}}, in1};
    assign w_div_zero = (in1 == '0);
    assign w_quot     = w_div_zero ? '1 : (in0 / in1);

    // Shifter: the whole in1 word is the amount, so oversize amounts saturate.
    assign w_sh_big = (in1 >= c_sh_limit);
    assign w_shamt  = in1[c_shw-1:0];
    assign w_shl    = w_sh_big ? '0 : (in0 << w_shamt);
    assign w_shr    = w_sh_big ? '0 : (in0 >> w_shamt);
    assign w_asr    = w_sh_big ? {WIDTH{in0[WIDTH-1]}}
                               : $unsigned($signed(in0) >>> w_shamt);

    // Result multiplexer; unused codes yield zero so out is never X.
    always_comb begin
        w_result = '0;
        case (select)
            c_op_add:   w_result = w_sum[WIDTH-1:0];
            c_op_sub:   w_result = w_diff[WIDTH-1:0];
            c_op_cmp:   w_result = w_diff[WIDTH-1:0];
            c_op_mul:   w_result = w_prod[WIDTH-1:0];
            c_op_div:   w_result = w_quot;
            c_op_and:   w_result = in0 & in1;
            c_op_or:    w_result = in0 | in1;
            c_op_xor:   w_result = in0 ^ in1;
            c_op_shl:   w_result = w_shl;
            c_op_shr:   w_result = w_shr;
            c_op_asr:   w_result = w_asr;
            c_op_passa: w_result = in0;
            c_op_passb: w_result = in1;
            default:    w_result = '0;
        endcase
    end

    assign out = w_result;

    assign w_sign_a = in0[WIDTH-1];
    assign w_sign_b = in1[WIDTH-1];
    assign w_sign_r = w_result[WIDTH-1];

    // Next-flag computation from the operation currently presented.
    always_comb begin
        w_z = (w_result == '0);
        w_n = w_sign_r;
        w_c = 1'b0;
        w_v = 1'b0;
        case (select)
            c_op_add: begin
                w_c = w_sum[WIDTH];
                w_v = (w_sign_a == w_sign_b) && (w_sign_r != w_sign_a);
            end
            c_op_sub, c_op_cmp: begin
                w_c = w_diff[WIDTH];
                w_v = (w_sign_a != w_sign_b) && (w_sign_r != w_sign_a);
            end
            c_op_mul: begin
                w_c = |w_prod[2*WIDTH-1:WIDTH];
            end
            c_op_div: begin
                w_c = w_div_zero;
            end
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    // Status register: reset clears, otherwise capture when enabled, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (flag_en) begin
            r_flag_z <= w_z;
            r_flag_n <= w_n;
            r_flag_c <= w_c;
            r_flag_v <= w_v;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_core
// Purpose  : Self-checking bench for alu_core. Stimulus pushes expected
//            results/flags into a scoreboard; a monitor pops and compares.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [3:0]  select;
    logic        flag_en;
    logic [15:0] out;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;

    alu_core #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in0     (in0),
        .in1     (in1),
        .select  (select),
        .flag_en (flag_en),
        .out     (out),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_c  (flag_c),
        .flag_v  (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_flag;
        logic [15:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    event  ev_sample;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 1'b0;

    // Model flag state as {z,n,c,v}
    logic [3:0] model_flags = 4'b0000;

    // Reference model computed with plain integer arithmetic on the operation rules.
    function automatic void ref_model(input logic [3:0] sel, input int a, input int b,
                                      output int r, output bit c, output bit v);
        longint sa, sb_, t, p, d;
        sa = (a >= 32768) ? a - 65536 : a;
        sb_ = (b >= 32768) ? b - 65536 : b;
        r = 0; c = 0; v = 0;
        case (sel)
            4'd0: begin
                t = longint'(a) + b;
                r = int'(t % 65536);
                c = (t > 65535);
                v = ((sa + sb_) > 32767) || ((sa + sb_) < -32768);
            end
            4'd1, 4'd12: begin
                r = (a - b + 65536) % 65536;
                c = (a < b);
                v = ((sa - sb_) > 32767) || ((sa - sb_) < -32768);
            end
            4'd2: begin
                p = longint'(a) * b;
                r = int'(p % 65536);
                c = (p >= 65536);
            end
            4'd3: begin
                if (b == 0) begin r = 65535; c = 1; end
                else r = a / b;
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = (b >= 16) ? 0 : int'((longint'(a) * (longint'(1) << b)) % 65536);
            4'd8: r = (b >= 16) ? 0 : a / (1 << b);
            4'd9: begin
                if (b >= 16) r = (sa < 0) ? 65535 : 0;
                else begin
                    d = longint'(1) << b;
                    if (sa >= 0) t = sa / d;
                    else t = -((-sa + d - 1) / d);
                    r = int'((t + 65536) % 65536);
                end
            end
            4'd10: r = a;
            4'd11: r = b;
            default: r = 0;
        endcase
    endfunction

    // Monitor: each sample request pops one expectation and compares it.
    initial begin
        item_t       it;
        logic [15:0] act;
        forever begin
            @(ev_sample);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: got sample with no expectation");
            end else begin
                it  = sb.pop_front();
                act = it.is_flag ? {12'b0, flag_z, flag_n, flag_c, flag_v} : out;
                if (act !== it.exp)
                    begin
                        n_bad++;
                        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                    end
            end
        end
    end

    // One cycle: drive at negedge, check out 2ns later, check flags after the edge.
    task automatic do_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input logic en, input logic rstn, input string name);
        int    r;
        bit    c, v;
        item_t it;
        @(negedge clk);
        select  = sel;
        in0     = a;
        in1     = b;
        flag_en = en;
        rst_n   = rstn;
        ref_model(sel, int'(a), int'(b), r, c, v);
        #2;
        it.is_flag = 1'b0; it.exp = r[15:0]; it.name = {name, "_out"};
        sb.push_back(it);
        -> ev_sample;
        if (!rstn)    model_flags = 4'b0000;
        else if (en)  model_flags = {(r == 0), (r >= 32768), c, v};
        @(posedge clk);
        #1;
        it.is_flag = 1'b1; it.exp = {12'b0, model_flags}; it.name = {name, "_flags"};
        sb.push_back(it);
        -> ev_sample;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            5: return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; flag_en = 1'b0; select = 4'd0; in0 = 16'd0; in1 = 16'd0;

        // Reset state, with out still tracking the inputs
        do_op(4'd0, 16'd13, 16'd6, 1'b1, 1'b0, "reset_add");
        do_op(4'd5, 16'd13, 16'd6, 1'b1, 1'b0, "reset_or");

        // Test plan with 13 / 6
        do_op(4'd0,  16'd13, 16'd6, 1'b1, 1'b1, "add");
        do_op(4'd1,  16'd13, 16'd6, 1'b1, 1'b1, "sub");
        do_op(4'd12, 16'd13, 16'd6, 1'b1, 1'b1, "cmp");
        do_op(4'd2,  16'd13, 16'd6, 1'b1, 1'b1, "mul");
        do_op(4'd3,  16'd13, 16'd6, 1'b1, 1'b1, "div");
        do_op(4'd4,  16'd13, 16'd6, 1'b1, 1'b1, "and");
        do_op(4'd5,  16'd13, 16'd6, 1'b1, 1'b1, "or");
        do_op(4'd6,  16'd13, 16'd6, 1'b1, 1'b1, "xor");
        do_op(4'd7,  16'd13, 16'd6, 1'b1, 1'b1, "shl");
        do_op(4'd8,  16'd13, 16'd6, 1'b1, 1'b1, "shr");
        do_op(4'd9,  16'd13, 16'd6, 1'b1, 1'b1, "asr");
        do_op(4'd11, 16'd13, 16'd6, 1'b1, 1'b1, "passb");
        do_op(4'd10, 16'd13, 16'd6, 1'b1, 1'b1, "passa");
        do_op(4'd13, 16'd13, 16'd6, 1'b1, 1'b1, "undef13");
        do_op(4'd14, 16'd13, 16'd6, 1'b1, 1'b1, "undef14");
        do_op(4'd15, 16'd13, 16'd6, 1'b1, 1'b1, "undef15");

        // Boundaries and overflow
        do_op(4'd3,  16'd13,    16'd0,  1'b1, 1'b1, "div_zero");
        do_op(4'd7,  16'd13,    16'd16, 1'b1, 1'b1, "shl_16");
        do_op(4'd9,  16'h8000,  16'd20, 1'b1, 1'b1, "asr_big");
        do_op(4'd0,  16'h7FFF,  16'd1,  1'b1, 1'b1, "add_ovf");
        do_op(4'd1,  16'h8000,  16'd1,  1'b1, 1'b1, "sub_ovf");
        do_op(4'd12, 16'd3,     16'd5,  1'b1, 1'b1, "cmp_lt");
        do_op(4'd0,  16'hFFFF,  16'd1,  1'b1, 1'b1, "add_wrap");

        // Flags hold with flag_en low while operations change
        do_op(4'd0,  16'h7FFF,  16'd1,  1'b0, 1'b1, "hold_add");
        do_op(4'd3,  16'd5,     16'd0,  1'b0, 1'b1, "hold_div");
        do_op(4'd12, 16'd3,     16'd5,  1'b0, 1'b1, "hold_cmp");

        // Reset with flag_en high clears, then capture resumes
        do_op(4'd12, 16'd3,     16'd5,  1'b1, 1'b0, "rst_en");
        do_op(4'd12, 16'd3,     16'd5,  1'b1, 1'b1, "resume");

        // Randomized operations, enables and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            logic [3:0]  s;
            s = 4'($urandom_range(0, 15));
            a = pick_operand();
            b = pick_operand();
            do_op(s, a, b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0),
                  $sformatf("rand%0d_sel%0d", i, s));
        end

        #20;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
